// File: rtl/rs_enc_ilv.sv
// Symbol-interleaved systematic RS encoder: depth LFSR channels,
// parity emitted p-major / channel-minor after the last data symbol.
module rs_enc_ilv #(
  parameter int n         = 255,
  parameter int check     = 30,
  parameter int m         = 8,
  parameter int irrpol    = 285,
  parameter int genstart  = 0,
  parameter int rootspace = 1,
  parameter int depth     = 4
) (
  input  logic         iclk,
  input  logic         ireset,
  input  logic         iclkena,
  input  logic         isop,
  input  logic         ival,
  input  logic         ieop,
  input  logic [m-1:0] idat,
  output logic         ordy,
  output logic         osop,
  output logic         oval,
  output logic         oeop,
  output logic [m-1:0] odat,
  output logic [((depth > 1) ? $clog2(depth) : 1)-1:0] ochan,
  output logic         oerr
);

  localparam int CW    = (depth > 1) ? $clog2(depth) : 1;
  localparam int PW    = $clog2(check + 1);
  localparam int LIMIT = depth * (n - check);
  localparam int SW    = $clog2(LIMIT + 2);
  localparam int NQ    = (1 << m) - 1;
  localparam int LW    = check * m;

  localparam logic [m-1:0]  POLY  = irrpol[m-1:0];
  localparam logic [CW-1:0] CLAST = CW'(depth - 1);
  localparam logic [PW-1:0] PLAST = PW'(check);
  localparam logic [SW-1:0] SLIM  = SW'(LIMIT);

  function automatic logic [m-1:0] xtime(
    input logic [m-1:0] a
  );
    return a[m-1] ? ((a << 1) ^ POLY) : (a << 1);
  endfunction

  function automatic logic [m-1:0] gf_mul(
    input logic [m-1:0] a,
    input logic [m-1:0] b
  );
    logic [m-1:0] r;
    logic [m-1:0] t;
    r = '0;
    t = a;
    for (int k = 0; k < m; k++) begin
      if (b[k]) r = r ^ t;
      t = xtime(t);
    end
    return r;
  endfunction

  function automatic logic [m-1:0] gf_pow(
    input int e
  );
    logic [m-1:0] r;
    r = '0;
    r[0] = 1'b1;
    for (int k = 0; k < e; k++) r = xtime(r);
    return r;
  endfunction

  // g(x) = prod (x + alpha^(genstart + i*rootspace)), coef k at [k*m +: m]
  function automatic logic [(check+1)*m-1:0] gen_poly();
    logic [(check+1)*m-1:0] g;
    logic [m-1:0]           root;
    g = '0;
    g[0] = 1'b1;
    for (int i = 0; i < check; i++) begin
      root = gf_pow((genstart + i * rootspace) % NQ);
      for (int j = check; j > 0; j--)
        g[j*m +: m] = g[(j-1)*m +: m] ^ gf_mul(g[j*m +: m], root);
      g[0 +: m] = gf_mul(g[0 +: m], root);
    end
    return g;
  endfunction

  localparam logic [(check+1)*m-1:0] GEN = gen_poly();

  // state index i (1..check) lives at [(i-1)*m +: m]
  function automatic logic [LW-1:0] lfsr_step(
    input logic [LW-1:0] s,
    input logic [m-1:0]  d
  );
    logic [LW-1:0] r;
    logic [m-1:0]  fb;
    fb = d ^ s[0 +: m];
    r  = '0;
    for (int i = 1; i < check; i++)
      r[(i-1)*m +: m] = s[i*m +: m] ^ gf_mul(fb, GEN[(check-i)*m +: m]);
    r[(check-1)*m +: m] = gf_mul(fb, GEN[0 +: m]);
    return r;
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } fsm_e;

  fsm_e state_q, state_d;

  logic [LW-1:0] lfsr_q [depth];
  logic [LW-1:0] lfsr_d [depth];
  logic [LW-1:0] base   [depth];

  logic [CW-1:0] cc_q, cc_d;
  logic [CW-1:0] pc_q, pc_d;
  logic [PW-1:0] p_q, p_d;
  logic [SW-1:0] sc_q, sc_d;
  logic [CW-1:0] ch_sel;

  logic          osop_q, osop_d;
  logic          oval_q, oval_d;
  logic          oeop_q, oeop_d;
  logic [m-1:0]  odat_q, odat_d;
  logic [CW-1:0] ochan_q, ochan_d;
  logic          oerr_q, oerr_d;

  logic take;
  logic restart;
  logic last;

  assign ordy    = (state_q != PARITY);
  assign take    = iclkena & ival & ordy & (isop | (state_q == DATA));
  assign restart = take & isop;
  assign last    = (state_q == PARITY) & (p_q == PLAST) & (pc_q == CLAST);

  assign osop  = osop_q;
  assign oval  = oval_q;
  assign oeop  = oeop_q;
  assign odat  = odat_q;
  assign ochan = ochan_q;
  assign oerr  = oerr_q;

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (restart) state_d = ieop ? PARITY : DATA;
      DATA:    if (take && ieop) state_d = PARITY;
      PARITY:  if (iclkena && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d  = lfsr_q;
    cc_d    = cc_q;
    pc_d    = pc_q;
    p_d     = p_q;
    sc_d    = sc_q;
    osop_d  = osop_q;
    oval_d  = oval_q;
    oeop_d  = oeop_q;
    odat_d  = odat_q;
    ochan_d = ochan_q;
    oerr_d  = oerr_q;
    ch_sel  = restart ? '0 : cc_q;
    for (int c = 0; c < depth; c++)
      base[c] = restart ? '0 : lfsr_q[c];
    if (iclkena) begin
      if (state_q == PARITY) begin
        oval_d  = 1'b1;
        osop_d  = 1'b0;
        oeop_d  = last;
        ochan_d = pc_q;
        odat_d  = lfsr_q[pc_q][m-1:0];
        lfsr_d[pc_q] = lfsr_q[pc_q] >> m;
        if (pc_q == CLAST) begin
          pc_d = '0;
          p_d  = p_q + 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end else begin
        oval_d = 1'b0;
        osop_d = 1'b0;
        oeop_d = 1'b0;
        if (take) begin
          lfsr_d         = base;
          lfsr_d[ch_sel] = lfsr_step(base[ch_sel], idat);
          oval_d  = 1'b1;
          osop_d  = isop;
          odat_d  = idat;
          ochan_d = ch_sel;
          cc_d    = (ch_sel == CLAST) ? '0 : ch_sel + 1'b1;
          // sc saturates one past the limit so the flag test stays valid
          if (restart) begin
            sc_d   = SW'(1);
            oerr_d = 1'b0;
          end else begin
            sc_d   = (sc_q > SLIM) ? sc_q : sc_q + 1'b1;
            oerr_d = oerr_q | (sc_q >= SLIM);
          end
          if (ieop) begin
            p_d  = PW'(1);
            pc_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      for (int c = 0; c < depth; c++) lfsr_q[c] <= '0;
      cc_q    <= '0;
      pc_q    <= '0;
      p_q     <= '0;
      sc_q    <= '0;
      osop_q  <= 1'b0;
      oval_q  <= 1'b0;
      oeop_q  <= 1'b0;
      odat_q  <= '0;
      ochan_q <= '0;
      oerr_q  <= 1'b0;
    end else begin
      lfsr_q  <= lfsr_d;
      cc_q    <= cc_d;
      pc_q    <= pc_d;
      p_q     <= p_d;
      sc_q    <= sc_d;
      osop_q  <= osop_d;
      oval_q  <= oval_d;
      oeop_q  <= oeop_d;
      odat_q  <= odat_d;
      ochan_q <= ochan_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule
